lp_stage_sequencer: RTL
=======================

# lp_stage_sequencer

Parametrised control sequencer for the LP (simplex) accelerator. It walks a configurable number of compute stages (pivot column, pivot row, tableau update, comparator, …) in strict order, one stage active at a time. It steers the shared operand mux and write-back demux, counts simplex iterations and reports termination status to the MicroBlaze. It sits between the MicroBlaze control registers, the tableau FIFO loader and the NUM_STAGES compute cores.

## Interface
- NUM_STAGES, 4, number of sequenced compute stages (≥2)
- ITER_W, 16, width of iteration counter
- MAX_ITER, 1000, iteration limit (used only with LP_ITER_LIMIT_EN)
- SEL_W (localparam), max(1, $clog2(NUM_STAGES)), select width

Ports:
- aclk  in  1  clock; all logic on rising edge
- areset  in  1  synchronous, active-high reset
- mblz_init  in  1  start request from MicroBlaze (level, sampled in IDLE)
- fifo_ready  in  1  tableau FIFO loaded
- fifo_stop  in  1  FIFO error/abort
- stage_done  in  NUM_STAGES  per-stage completion pulse
- stage_stop  in  NUM_STAGES  per-stage abort request
- complete  in  1  optimality flag; sampled with stage_done of last stage
- stop  out  1  global halt to datapath
- fifo_init  out  1  request FIFO load
- stage_valid  out  NUM_STAGES  one-hot stage enable
- mux_sel  out  SEL_W  operand mux select (index of active stage)
- demux_sel  out  SEL_W  write-back demux select
- wb_valid  out  1  one-cycle write-back strobe qualifying demux_sel
- iter_count  out  ITER_W  completed iterations
- mblz_done  out  1  one-cycle termination pulse
- status  out  2  00 running/idle, 01 optimal, 10 stopped, 11 iteration limit

## Operation
- States: IDLE, LOAD, RUN, DONE, ABORT. Internal stage index k (SEL_W bits).
- IDLE: stop=1. On mblz_init=1 go to LOAD: clear iter_count, set status=00, fifo_init=1, stop=0.
- LOAD: hold fifo_init=1 until fifo_ready=1. Then go to RUN with k=0, fifo_init=0.
- RUN: stage_valid = one-hot(k), mux_sel=k.
  - stage_done[k]=1 registers demux_sel=k and wb_valid=1.
  - If k<NUM_STAGES-1: k←k+1.
  - If k=NUM_STAGES-1: iter_count←iter_count+1. If complete=1, go to DONE; else k←0.
  - stage_done bits for j≠k are ignored.
- DONE: mblz_done=1 for one cycle, status=01, stop=1. Next state is IDLE.
- ABORT is entered from LOAD or RUN when any stage_stop bit or fifo_stop is 1. On entry: stage_valid=0, fifo_init=0, stop=1, status=10, mblz_done pulses. Next state is IDLE.
- status and iter_count hold their values in IDLE until the next start.
- mblz_init is ignored outside IDLE.
- Arithmetic: iter_count wraps modulo 2^ITER_W. k never exceeds NUM_STAGES-1. This also holds for non-power-of-two NUM_STAGES.

## Timing
- Reset values: stop=1, fifo_init=0, stage_valid=0, mux_sel=0, demux_sel=0, wb_valid=0, iter_count=0, mblz_done=0, status=00. State=IDLE.
- All outputs are registered. A response appears on the cycle after the causing input.
- Stage handoff: stage_done[k] at edge n gives stage_valid[k]=0 and stage_valid[k+1]=1 at n+1. There are no idle cycles between stages.
- wb_valid is high exactly one cycle per accepted stage_done.
- Stop and done in the same cycle: stop wins. wb_valid is not issued and iter_count is not incremented.
- fifo_ready and fifo_stop together in LOAD: ABORT.
- areset mid-operation: all outputs return to reset values on the next edge. The in-flight iteration is discarded.
- Stop inputs are ignored in IDLE and DONE.

## Configuration
- LP_ITER_LIMIT_EN defined: at the last-stage stage_done with complete=0, if iter_count+1 ≥ MAX_ITER, go to ABORT with status=11 instead of returning to k=0. complete=1 on that same edge takes priority and gives status=01.
- LP_ITER_LIMIT_EN undefined: there is no limit, MAX_ITER is unused, and status=11 is never produced.

## Test plan
- Reset then idle: areset=1 for 2 cycles → stop=1, stage_valid=0, status=00. Holding mblz_init=0 for 10 cycles keeps state IDLE.
- Single iteration, NUM_STAGES=4: start, fifo_ready, stage_done pulses 0..3 with complete=1 on stage 3 → stage_valid goes 0001→0010→0100→1000. wb_valid is seen 4× with demux_sel 0,1,2,3. mblz_done pulse, status=01, iter_count=1.
- Three iterations: complete=0 on the first two last-stage dones → mux_sel returns to 0 twice, iter_count=3, status=01.
- Abort: stage_stop[2]=1 together with stage_done[2] during stage 2 → no wb_valid, stop=1, status=10, IDLE next cycle. Also check that a stray stage_done[0] while stage 1 is active is ignored.
- Limit (LP_ITER_LIMIT_EN, MAX_ITER=3, complete never set) → status=11 after iter_count reaches 3. Without the macro, the sequencer runs on and iter_count passes 3.
- NUM_STAGES=3 and areset asserted mid-stage 1 → k never reaches 3, and all outputs are at reset values one cycle after areset.

Source files
------------

// File: rtl/lp_stage_sequencer.sv
// Stage sequencer for the LP accelerator: walks NUM_STAGES compute cores in order, counts simplex iterations.
// Optional iteration limit enabled by defining LP_ITER_LIMIT_EN.
module lp_stage_sequencer #(
    parameter  int unsigned NUM_STAGES = 4,
    parameter  int unsigned ITER_W     = 16,
    parameter  int unsigned MAX_ITER   = 1000,
    localparam int unsigned SEL_W      = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1
) (
    input  logic                  aclk,
    input  logic                  areset,
    input  logic                  mblz_init,
    input  logic                  fifo_ready,
    input  logic                  fifo_stop,
    input  logic [NUM_STAGES-1:0] stage_done,
    input  logic [NUM_STAGES-1:0] stage_stop,
    input  logic                  complete,
    output logic                  stop,
    output logic                  fifo_init,
    output logic [NUM_STAGES-1:0] stage_valid,
    output logic [SEL_W-1:0]      mux_sel,
    output logic [SEL_W-1:0]      demux_sel,
    output logic                  wb_valid,
    output logic [ITER_W-1:0]     iter_count,
    output logic                  mblz_done,
    output logic [1:0]            status
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DONE,
        S_ABORT
    } state_e;

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_OPT   = 2'b01;
    localparam logic [1:0] ST_STOP  = 2'b10;
    localparam logic [1:0] ST_LIMIT = 2'b11;

    localparam logic [SEL_W-1:0] K_LAST     = SEL_W'(NUM_STAGES - 1);
    localparam logic [ITER_W:0]  MAX_ITER_W = (ITER_W + 1)'(MAX_ITER);
`ifdef LP_ITER_LIMIT_EN
    localparam bit LIMIT_EN = 1'b1;
`else
    localparam bit LIMIT_EN = 1'b0;
`endif

    state_e                  state_q, state_d;
    logic [SEL_W-1:0]        k_q, k_d;
    logic                    stop_q, stop_d;
    logic                    fifo_init_q, fifo_init_d;
    logic [NUM_STAGES-1:0]   stage_valid_q, stage_valid_d;
    logic [SEL_W-1:0]        mux_sel_q, mux_sel_d;
    logic [SEL_W-1:0]        demux_sel_q, demux_sel_d;
    logic                    wb_valid_q, wb_valid_d;
    logic [ITER_W-1:0]       iter_count_q, iter_count_d;
    logic                    mblz_done_q, mblz_done_d;
    logic [1:0]              status_q, status_d;

    logic                    any_stop_c;
    logic                    done_k_c;
    logic                    limit_hit_c;

    assign any_stop_c  = fifo_stop | (|stage_stop);
    assign done_k_c    = stage_done[k_q];
    // Unwrapped compare so a counter about to wrap still sees the limit
    assign limit_hit_c = LIMIT_EN && (({1'b0, iter_count_q} + (ITER_W + 1)'(1)) >= MAX_ITER_W);

    always_comb begin
        state_d       = state_q;
        k_d           = k_q;
        stop_d        = stop_q;
        fifo_init_d   = fifo_init_q;
        stage_valid_d = stage_valid_q;
        mux_sel_d     = mux_sel_q;
        demux_sel_d   = demux_sel_q;
        wb_valid_d    = 1'b0;
        iter_count_d  = iter_count_q;
        mblz_done_d   = 1'b0;
        status_d      = status_q;

        case (state_q)
            S_IDLE: begin
                stop_d = 1'b1;
                if (mblz_init) begin
                    state_d      = S_LOAD;
                    iter_count_d = '0;
                    status_d     = ST_RUN;
                    fifo_init_d  = 1'b1;
                    stop_d       = 1'b0;
                    k_d          = '0;
                    mux_sel_d    = '0;
                end
            end
            S_LOAD: begin
                if (any_stop_c) begin
                    state_d       = S_ABORT;
                    stage_valid_d = '0;
                    fifo_init_d   = 1'b0;
                    stop_d        = 1'b1;
                    status_d      = ST_STOP;
                    mblz_done_d   = 1'b1;
                end else if (fifo_ready) begin
                    state_d       = S_RUN;
                    fifo_init_d   = 1'b0;
                    k_d           = '0;
                    mux_sel_d     = '0;
                    stage_valid_d = NUM_STAGES'(1);
                end
            end
            S_RUN: begin
                // Abort beats a same-cycle stage_done: no write-back, no count
                if (any_stop_c) begin
                    state_d       = S_ABORT;
                    stage_valid_d = '0;
                    stop_d        = 1'b1;
                    status_d      = ST_STOP;
                    mblz_done_d   = 1'b1;
                end else if (done_k_c) begin
                    demux_sel_d = k_q;
                    wb_valid_d  = 1'b1;
                    if (k_q != K_LAST) begin
                        k_d           = k_q + SEL_W'(1);
                        mux_sel_d     = k_d;
                        stage_valid_d = NUM_STAGES'(1) << k_d;
                    end else begin
                        iter_count_d = iter_count_q + ITER_W'(1);
                        if (complete) begin
                            state_d       = S_DONE;
                            stage_valid_d = '0;
                            stop_d        = 1'b1;
                            status_d      = ST_OPT;
                            mblz_done_d   = 1'b1;
                        end else if (limit_hit_c) begin
                            state_d       = S_ABORT;
                            stage_valid_d = '0;
                            stop_d        = 1'b1;
                            status_d      = ST_LIMIT;
                            mblz_done_d   = 1'b1;
                        end else begin
                            k_d           = '0;
                            mux_sel_d     = '0;
                            stage_valid_d = NUM_STAGES'(1);
                        end
                    end
                end
            end
            S_DONE, S_ABORT: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_q       <= S_IDLE;
            k_q           <= '0;
            stop_q        <= 1'b1;
            fifo_init_q   <= 1'b0;
            stage_valid_q <= '0;
            mux_sel_q     <= '0;
            demux_sel_q   <= '0;
            wb_valid_q    <= 1'b0;
            iter_count_q  <= '0;
            mblz_done_q   <= 1'b0;
            status_q      <= ST_RUN;
        end else begin
            state_q       <= state_d;
            k_q           <= k_d;
            stop_q        <= stop_d;
            fifo_init_q   <= fifo_init_d;
            stage_valid_q <= stage_valid_d;
            mux_sel_q     <= mux_sel_d;
            demux_sel_q   <= demux_sel_d;
            wb_valid_q    <= wb_valid_d;
            iter_count_q  <= iter_count_d;
            mblz_done_q   <= mblz_done_d;
            status_q      <= status_d;
        end
    end

    assign stop        = stop_q;
    assign fifo_init   = fifo_init_q;
    assign stage_valid = stage_valid_q;
    assign mux_sel     = mux_sel_q;
    assign demux_sel   = demux_sel_q;
    assign wb_valid    = wb_valid_q;
    assign iter_count  = iter_count_q;
    assign mblz_done   = mblz_done_q;
    assign status      = status_q;

endmodule
